aes_stream_sequencer: RTL and testbench
=======================================

// Module: aes_stream_sequencer
// PURPOSE
//  Upstream/downstream sequencer for the AES core: packs 32-bit bus words into 128-bit key/data blocks,
//  drives keyword/keyEna/input_data/encrypt into the core and waits a fixed core latency.
//  Then captures AESresult and streams it back out as four 32-bit words.
//  Sits between the HCLK-domain bus slave and the AES core; all core timing is owned here.
// PARAMETERS
//  KEY_LAT  11  cycles from keyEna pulse until subkeys are valid (no data issued before)
//  AES_LAT  12  cycles from input_data/encrypt stable until AESresult is valid to capture
// PORTS
//  HCLK        in   1    clock
//  n_rst       in   1    async active-low reset
//  in_valid    in   1    input word valid
//  in_ready    out  1    sequencer accepts word this cycle
//  in_data     in   32   input word; first word of a group -> bits [127:96]
//  in_is_key   in   1    word belongs to a key group (1) or data group (0)
//  in_encrypt  in   1    mode, sampled on first word of a data group
//  keyword     out  128  key to core; held until next key group completes
//  keyEna      out  1    1-cycle pulse when key group completes
//  input_data  out  128  block to core; held through RUN
//  encrypt     out  1    mode to core; held through RUN
//  AESresult   in   128  core result
//  out_valid   out  1    output word valid
//  out_ready   in   1    downstream accepts output word
//  out_data    out  32   output word, [127:96] first
//  err         out  1    1-cycle pulse: key/data flag changed inside a group
// BEHAVIOUR
//  Reset: all outputs 0, state COLLECT, word count 0, in_ready 0 during reset then 1 in COLLECT.
//  States: COLLECT -> KEY_WAIT | RUN; KEY_WAIT -> COLLECT; RUN -> DRAIN; DRAIN -> COLLECT.
//  COLLECT: in_ready=1; word taken on in_valid&in_ready; count 0..3; 4th word completes group.
//   Key group done: keyword<=packed, keyEna=1 next cycle only, load counter KEY_LAT-1, go KEY_WAIT.
//   Data group done: input_data<=packed, encrypt<=sampled mode, load counter AES_LAT-1, go RUN.
//   Flag mismatch vs first word of group: err pulse, partial discarded, this word starts a new group (count=1).
//   Data group before any key since reset: accepted and processed with keyword=0 (no special case).
//  KEY_WAIT / RUN: in_ready=0; counter decrements each cycle; leaves state on the cycle after it reads 0.
//   RUN exit: capture AESresult into 128-bit result register, go DRAIN.
//  DRAIN: out_valid=1, out_data=result word idx (0..3); advance on out_valid&out_ready;
//   out_data stable while out_ready=0; after idx 3 accepted: out_valid=0, go COLLECT same edge.
//  No overlap: a new group is never accepted before DRAIN empties (throughput 1 block per 4+AES_LAT+4+ cycles).
//  n_rst asserted mid-operation: immediate return to reset values; partial group and result lost, keyword cleared.
//  Counter width = $clog2(max(KEY_LAT,AES_LAT)+1); KEY_LAT, AES_LAT >= 1.
// CONFIGURATION
//  AES_SEQ_CBC_EN defined: CBC chaining with 128-bit chain register, cleared to 0 on n_rst and on keyEna.
//   Encrypt: input_data = packed ^ chain; chain <= AESresult at RUN exit; output = AESresult.
//   Decrypt: input_data = packed; output = AESresult ^ chain; chain <= packed ciphertext at RUN exit.
//  Not defined: ECB; input_data = packed, output = AESresult, no chain register.
// STRUCTURE
//  aes_seq_pkg: state enum (COLLECT,KEY_WAIT,RUN,DRAIN), AES_BLK_W=128, AES_WORD_W=32,
//   AES_WORDS=4, function word_of(blk,idx) returning bits [127-32*idx -: 32].
//  Sub-module aes_out_serializer: 128-bit load + 4-word valid/ready drain, done pulse to parent FSM.
// TESTING
//  1 Reset: n_rst low -> all outputs 0; release -> in_ready=1, out_valid=0.
//  2 Key 000102..0f as 4 key words -> keyword=000102030405060708090a0b0c0d0e0f, keyEna high 1 cycle,
//    in_ready=0 exactly KEY_LAT cycles.
//  3 FIPS-197 data 00112233..eeff, encrypt=1 -> input_data stable AES_LAT cycles; out words
//    69c4e0d8,6a7b0430,d8cdb780,70b4c55a in order.
//  4 Decrypt of 69c4e0d8.. with same key -> out 00112233,44556677,8899aabb,ccddeeff;
//    out_ready toggled 1/0 -> each word held until accepted.
//  5 Key word, key word, data word -> err pulse 1 cycle, no keyEna; 3 more data words -> one block issued.
//  6 n_rst pulse during RUN and during DRAIN word 2 -> outputs 0, no further out_valid;
//    CBC build: two identical plaintext blocks give different ciphertexts.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// -----------------------------------------------------------------------------
// aes_seq_pkg
//   Shared definitions for the AES stream sequencer: block/word geometry,
//   the sequencer state encoding and a helper that slices one 32-bit word out
//   of a 128-bit block (word 0 is the most significant word).
//   No ports; imported by aes_out_serializer and aes_stream_sequencer.
// -----------------------------------------------------------------------------
package aes_seq_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_WORD_W = 32;
  localparam int AES_WORDS  = 4;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    KEY_WAIT = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } seq_state_e;

  // Plain-vector state constants so the FSM register stays a logic vector.
  localparam logic [1:0] ST_COLLECT  = COLLECT;
  localparam logic [1:0] ST_KEY_WAIT = KEY_WAIT;
  localparam logic [1:0] ST_RUN      = RUN;
  localparam logic [1:0] ST_DRAIN    = DRAIN;

  // Word idx of a block, idx 0 = bits [127:96].
  function automatic logic [AES_WORD_W-1:0] word_of(input logic [AES_BLK_W-1:0] blk,
                                                    input logic [1:0]           idx);
    return blk[(AES_BLK_W-1) - AES_WORD_W*int'(idx) -: AES_WORD_W];
  endfunction

endpackage

// File: rtl/aes_out_serializer.sv
// -----------------------------------------------------------------------------
// aes_out_serializer
//   Holds one 128-bit result block and streams it out as four 32-bit words,
//   most significant word first, over a valid/ready handshake.
//   Ports:
//     HCLK      in   clock
//     n_rst     in   async active-low reset
//     load      in   capture blk and start a new 4-word drain
//     blk       in   128-bit block to serialise
//     out_ready in   downstream accepts the current word
//     out_valid out  current word valid
//     out_data  out  current word (0 while idle)
//     done      out  combinational: last word is being accepted this cycle
// -----------------------------------------------------------------------------
module aes_out_serializer
  import aes_seq_pkg::*;
(
  input  logic                  HCLK,
  input  logic                  n_rst,
  input  logic                  load,
  input  logic [AES_BLK_W-1:0]  blk,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [AES_WORD_W-1:0] out_data,
  output logic                  done
);

  logic [AES_BLK_W-1:0]  blk_reg;
  logic [1:0]            idx_reg;
  logic                  valid_reg;
  logic [AES_WORD_W-1:0] word_sel [AES_WORDS];

  for (genvar gi = 0; gi < AES_WORDS; gi++) begin : g_word
    assign word_sel[gi] = word_of(blk_reg, 2'(gi));
  end

  assign out_valid = valid_reg;
  assign out_data  = valid_reg ? word_sel[idx_reg] : '0;
  // Done is combinational so the parent leaves DRAIN on the very edge that
  // retires the last word.
  assign done      = valid_reg & out_ready & (idx_reg == 2'(AES_WORDS-1));

  always_ff @(posedge HCLK or negedge n_rst) begin
    if (!n_rst) begin
      blk_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      blk_reg   <= blk;
      idx_reg   <= '0;
      valid_reg <= 1'b1;
    end else if (valid_reg && out_ready) begin
      idx_reg <= idx_reg + 2'd1;
      if (done) begin
        valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aes_stream_sequencer.sv
// -----------------------------------------------------------------------------
// aes_stream_sequencer
//   Packs 32-bit bus words into 128-bit key/data blocks, drives the AES core
//   (keyword/keyEna/input_data/encrypt), waits the fixed core latency, captures
//   AESresult and streams it back out as four 32-bit words. One block in
//   flight at a time; no new input is accepted until the result has drained.
//
//   Build option: define AES_SEQ_CBC_EN for CBC chaining (chain register
//   cleared on reset and whenever a new key is loaded). Default build is ECB.
//
//   Parameters:
//     KEY_LAT  cycles from keyEna until subkeys are valid (>= 1)
//     AES_LAT  cycles from input_data/encrypt stable until AESresult valid (>= 1)
//   Ports:
//     HCLK, n_rst                 clock, async active-low reset
//     in_valid/in_ready/in_data   input word stream, first word -> [127:96]
//     in_is_key                   word belongs to a key group (1) or data group (0)
//     in_encrypt                  mode, taken from the first word of a data group
//     keyword, keyEna             key to core, 1-cycle load pulse
//     input_data, encrypt         block and mode to core, held through RUN
//     AESresult                   core result
//     out_valid/out_ready/out_data output word stream, [127:96] first
//     err                         1-cycle pulse: key/data flag changed inside a group
// -----------------------------------------------------------------------------
module aes_stream_sequencer
  import aes_seq_pkg::*;
#(
  parameter int KEY_LAT = 11,
  parameter int AES_LAT = 12
) (
  input  logic                  HCLK,
  input  logic                  n_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AES_WORD_W-1:0] in_data,
  input  logic                  in_is_key,
  input  logic                  in_encrypt,
  output logic [AES_BLK_W-1:0]  keyword,
  output logic                  keyEna,
  output logic [AES_BLK_W-1:0]  input_data,
  output logic                  encrypt,
  input  logic [AES_BLK_W-1:0]  AESresult,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AES_WORD_W-1:0] out_data,
  output logic                  err
);

  localparam int LAT_MAX = (KEY_LAT > AES_LAT) ? KEY_LAT : AES_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  logic [1:0]            state_reg;
  logic [1:0]            wcnt_reg;
  logic                  grp_key_reg;
  logic                  grp_enc_reg;
  logic [AES_WORD_W-1:0] pack_reg [0:2];
  logic [AES_BLK_W-1:0]  keyword_reg;
  logic                  keyena_reg;
  logic [AES_BLK_W-1:0]  input_data_reg;
  logic                  encrypt_reg;
  logic                  err_reg;
  logic [CNT_W-1:0]      cnt_reg;
  // Low through reset and for the first cycle after it, so in_ready stays
  // low while n_rst is asserted even though the state register reads COLLECT.
  logic                  alive_reg;

  logic                  hs;
  logic                  grp_mismatch;
  logic                  key_done;
  logic                  run_exit;
  logic                  drain_done;
  logic [AES_BLK_W-1:0]  full_blk;
  logic [AES_BLK_W-1:0]  data_in_next;
  logic [AES_BLK_W-1:0]  result_next;

  assign in_ready     = alive_reg & (state_reg == ST_COLLECT);
  assign hs           = in_valid & in_ready;
  // A flag change only matters once a group has started.
  assign grp_mismatch = (wcnt_reg != 2'd0) & (in_is_key != grp_key_reg);
  assign full_blk     = {pack_reg[0], pack_reg[1], pack_reg[2], in_data};
  assign key_done     = hs & ~grp_mismatch & (wcnt_reg == 2'd3) & grp_key_reg;
  assign run_exit     = (state_reg == ST_RUN) & (cnt_reg == '0);

`ifdef AES_SEQ_CBC_EN
  logic [AES_BLK_W-1:0] chain_reg;

  // Encrypt whitens the plaintext with the previous ciphertext; decrypt
  // unwhitens the core output with the previous ciphertext.
  assign data_in_next = grp_enc_reg ? (full_blk ^ chain_reg) : full_blk;
  assign result_next  = encrypt_reg ? AESresult : (AESresult ^ chain_reg);

  always_ff @(posedge HCLK or negedge n_rst) begin
    if (!n_rst) begin
      chain_reg <= '0;
    end else if (key_done) begin
      chain_reg <= '0;
    end else if (run_exit) begin
      // Next chain value is always the ciphertext of this block: the core
      // output when encrypting, the block that was fed in when decrypting.
      chain_reg <= encrypt_reg ? AESresult : input_data_reg;
    end
  end
`else
  assign data_in_next = full_blk;
  assign result_next  = AESresult;
`endif

  aes_out_serializer u_ser (
    .HCLK      (HCLK),
    .n_rst     (n_rst),
    .load      (run_exit),
    .blk       (result_next),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .done      (drain_done)
  );

  always_ff @(posedge HCLK or negedge n_rst) begin
    if (!n_rst) begin
      state_reg      <= ST_COLLECT;
      wcnt_reg       <= '0;
      grp_key_reg    <= 1'b0;
      grp_enc_reg    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        pack_reg[i] <= '0;
      end
      keyword_reg    <= '0;
      keyena_reg     <= 1'b0;
      input_data_reg <= '0;
      encrypt_reg    <= 1'b0;
      err_reg        <= 1'b0;
      cnt_reg        <= '0;
      alive_reg      <= 1'b0;
    end else begin
      keyena_reg <= 1'b0;
      err_reg    <= 1'b0;
      alive_reg  <= 1'b1;
      case (state_reg)
        ST_COLLECT: begin
          if (hs) begin
            if (grp_mismatch) begin
              // Drop the partial group; this word becomes word 0 of a new one.
              err_reg     <= 1'b1;
              grp_key_reg <= in_is_key;
              grp_enc_reg <= in_encrypt;
              pack_reg[0] <= in_data;
              wcnt_reg    <= 2'd1;
            end else if (wcnt_reg == 2'd3) begin
              wcnt_reg <= '0;
              if (grp_key_reg) begin
                keyword_reg <= full_blk;
                keyena_reg  <= 1'b1;
                cnt_reg     <= CNT_W'(KEY_LAT - 1);
                state_reg   <= ST_KEY_WAIT;
              end else begin
                input_data_reg <= data_in_next;
                encrypt_reg    <= grp_enc_reg;
                cnt_reg        <= CNT_W'(AES_LAT - 1);
                state_reg      <= ST_RUN;
              end
            end else begin
              if (wcnt_reg == 2'd0) begin
                grp_key_reg <= in_is_key;
                grp_enc_reg <= in_encrypt;
              end
              pack_reg[wcnt_reg] <= in_data;
              wcnt_reg           <= wcnt_reg + 2'd1;
            end
          end
        end
        ST_KEY_WAIT, ST_RUN: begin
          // Leave on the cycle after the counter reads zero, giving exactly
          // KEY_LAT / AES_LAT cycles in the wait state.
          if (cnt_reg == '0) begin
            state_reg <= (state_reg == ST_KEY_WAIT) ? ST_COLLECT : ST_DRAIN;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_reg <= ST_COLLECT;
          end
        end
        default: state_reg <= ST_COLLECT;
      endcase
    end
  end

  assign keyword    = keyword_reg;
  assign keyEna     = keyena_reg;
  assign input_data = input_data_reg;
  assign encrypt    = encrypt_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_aes_stream_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_stream_sequencer
//   Self-checking bench for aes_stream_sequencer. A stand-in AES core answers
//   the FIPS-197 example vectors exactly and otherwise applies an invertible
//   scramble; its output is garbage until the block has been stable long
//   enough. A group/queue reference model predicts keyword, input_data,
//   err and the output word stream. Build with AES_SEQ_CBC_EN to match a CBC
//   build of the design.
// -----------------------------------------------------------------------------
module tb_aes_stream_sequencer;

  localparam int KEY_LAT = 11;
  localparam int AES_LAT = 12;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MAGIC    = 128'h5a3c96e1_0f1e2d3c_a5b4c3d2_e1f00f1e;

  logic         HCLK = 1'b0;
  logic         n_rst = 1'b0;
  logic         in_valid, in_ready, in_is_key, in_encrypt;
  logic [31:0]  in_data;
  logic [127:0] keyword, input_data, AESresult;
  logic         keyEna, encrypt, out_valid, out_ready, err;
  logic [31:0]  out_data;

  aes_stream_sequencer #(.KEY_LAT(KEY_LAT), .AES_LAT(AES_LAT)) dut (
    .HCLK       (HCLK),
    .n_rst      (n_rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_is_key  (in_is_key),
    .in_encrypt (in_encrypt),
    .keyword    (keyword),
    .keyEna     (keyEna),
    .input_data (input_data),
    .encrypt    (encrypt),
    .AESresult  (AESresult),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .err        (err)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- stand-in AES core ----------------
  function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] d,
                                          input logic e);
    logic [127:0] x;
    if (k == FIPS_KEY && e && d == FIPS_PT) return FIPS_CT;
    if (k == FIPS_KEY && !e && d == FIPS_CT) return FIPS_PT;
    if (e) begin
      x = d ^ k;
      return {x[119:0], x[127:120]} ^ MAGIC;
    end
    x = d ^ MAGIC;
    return {x[7:0], x[127:8]} ^ k;
  endfunction

  // Cycles since the last accepted input word; result is only meaningful
  // once the block has been presented for AES_LAT cycles.
  int stab = 0;
  always @(posedge HCLK) begin
    if (in_valid && in_ready) stab <= 0;
    else if (stab < 1000)     stab <= stab + 1;
  end
  always @(negedge HCLK) begin
    if (stab >= AES_LAT - 1) AESresult = core_f(keyword, input_data, encrypt);
    else                     AESresult = {$urandom, $urandom, $urandom, $urandom};
  end

  // ---------------- reference model ----------------
  logic [127:0] m_key, m_chain;
  int           g_cnt;
  logic         g_key, g_enc;
  logic [31:0]  g_buf [4];
  logic [31:0]  exp_q [$];

  task automatic model_reset();
    m_key   = '0;
    m_chain = '0;
    g_cnt   = 0;
    g_key   = 1'b0;
    g_enc   = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_zero(input string where);
    check({where, "_in_ready"},   128'(in_ready), 128'(0));
    check({where, "_keyword"},    keyword, '0);
    check({where, "_keyEna"},     128'(keyEna), 128'(0));
    check({where, "_input_data"}, input_data, '0);
    check({where, "_encrypt"},    128'(encrypt), 128'(0));
    check({where, "_out_valid"},  128'(out_valid), 128'(0));
    check({where, "_out_data"},   128'(out_data), 128'(0));
    check({where, "_err"},        128'(err), 128'(0));
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic do_reset(input string where);
    n_rst = 1'b0;
    #1;
    check_zero(where);
    repeat (3) @(negedge HCLK);
    check_zero({where, "_held"});
    n_rst = 1'b1;
    model_reset();
    @(negedge HCLK);
    check({where, "_rel_in_ready"},  128'(in_ready), 128'(1));
    check({where, "_rel_out_valid"}, 128'(out_valid), 128'(0));
    $display("reset %s done", where);
  endtask

  task automatic drain(input int n, input bit toggle);
    int got = 0;
    int guard = 0;
    bit r;
    bit ph = 1'b0;
    while (got < n && guard < 400) begin
      guard++;
      check("drain_out_valid", 128'(out_valid), 128'(1));
      check("drain_out_data",  128'(out_data), 128'(exp_q[0]));
      check("drain_in_ready",  128'(in_ready), 128'(0));
      if (toggle) begin
        r  = ph;
        ph = ~ph;
      end else begin
        r = 1'($urandom_range(0, 1));
      end
      out_ready = r;
      @(negedge HCLK);
      if (r) begin
        $display("out word %0d = %h", got, exp_q[0]);
        void'(exp_q.pop_front());
        got++;
      end
    end
    out_ready = 1'b0;
    check("drain_count", 128'(got), 128'(n));
    if (n == 4) begin
      check("drain_end_valid", 128'(out_valid), 128'(0));
      check("drain_end_ready", 128'(in_ready), 128'(1));
    end
  endtask

  // mode: 0 = do not wait for completion, 1 = wait + random drain, 2 = wait + toggled drain
  task automatic send_word(input logic [31:0] d, input logic k, input logic e, input int mode);
    logic         exp_err;
    logic [127:0] blk, exp_in, res;
    int           guard, lat, bad;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge HCLK);
      guard++;
    end
    check("ready_wait", 128'(in_ready), 128'(1));

    exp_err = (g_cnt != 0) && (k != g_key);
    if (exp_err) g_cnt = 0;
    if (g_cnt == 0) begin
      g_key = k;
      g_enc = e;
    end
    g_buf[g_cnt] = d;
    g_cnt++;

    in_valid = 1'b1; in_data = d; in_is_key = k; in_encrypt = e;
    @(negedge HCLK);
    in_valid = 1'b0; in_data = $urandom; in_is_key = 1'($urandom); in_encrypt = 1'($urandom);
    $display("word %h key=%0b enc=%0b err_exp=%0b", d, k, e, exp_err);
    check("err", 128'(err), 128'(exp_err));

    if (g_cnt < 4) begin
      check("keyEna_idle", 128'(keyEna), 128'(0));
      check("in_ready_collect", 128'(in_ready), 128'(1));
    end else begin
      g_cnt = 0;
      blk = {g_buf[0], g_buf[1], g_buf[2], g_buf[3]};
      if (g_key) begin
        m_key   = blk;
        m_chain = '0;
        check("keyEna", 128'(keyEna), 128'(1));
        check("keyword", keyword, blk);
        lat = 0;
        while (!in_ready && lat < 100) begin
          lat++;
          @(negedge HCLK);
          if (lat == 1) check("keyEna_pulse", 128'(keyEna), 128'(0));
        end
        check("key_wait_cycles", 128'(lat), 128'(KEY_LAT));
        check("keyword_held", keyword, blk);
      end else begin
`ifdef AES_SEQ_CBC_EN
        if (g_enc) begin
          exp_in  = blk ^ m_chain;
          res     = core_f(m_key, exp_in, 1'b1);
          m_chain = res;
        end else begin
          exp_in  = blk;
          res     = core_f(m_key, blk, 1'b0) ^ m_chain;
          m_chain = blk;
        end
`else
        exp_in = blk;
        res    = core_f(m_key, blk, g_enc);
`endif
        for (int i = 0; i < 4; i++) exp_q.push_back(res[127-32*i -: 32]);
        check("input_data", input_data, exp_in);
        check("encrypt", 128'(encrypt), 128'(g_enc));
        check("keyEna_data", 128'(keyEna), 128'(0));
        if (mode != 0) begin
          lat = 0;
          bad = 0;
          while (!out_valid && lat < 100) begin
            if (input_data !== exp_in || encrypt !== g_enc || in_ready) bad++;
            lat++;
            @(negedge HCLK);
          end
          check("run_stable", 128'(bad), 128'(0));
          check("run_cycles", 128'(lat), 128'(AES_LAT));
          drain(4, mode == 2);
        end
      end
    end
  endtask

  task automatic send_block(input logic [127:0] b, input logic k, input logic e, input int mode);
    for (int i = 0; i < 4; i++) send_word(b[127-32*i -: 32], k, e, mode);
  endtask

  task automatic watch_quiet(input string tag);
    int seen = 0;
    for (int i = 0; i < AES_LAT + 8; i++) begin
      if (out_valid) seen++;
      @(negedge HCLK);
    end
    check(tag, 128'(seen), 128'(0));
  endtask

  initial begin
    int guard;
    logic [127:0] rb;
    logic rk, re;
    in_valid = 1'b0; in_data = '0; in_is_key = 1'b0; in_encrypt = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge HCLK);

    // Reset values and release
    do_reset("por");

    // FIPS key load, encrypt, decrypt with toggled out_ready
    send_block(FIPS_KEY, 1'b1, 1'b0, 1);
    send_block(FIPS_PT, 1'b0, 1'b1, 1);
    send_block(FIPS_CT, 1'b0, 1'b0, 2);

    // Key, key, data -> err, then 3 more data words complete one block
    send_word(32'hdeadbeef, 1'b1, 1'b0, 1);
    send_word(32'hcafef00d, 1'b1, 1'b0, 1);
    send_word(32'h00112233, 1'b0, 1'b1, 1);
    send_word(32'h44556677, 1'b0, 1'b0, 1);
    send_word(32'h8899aabb, 1'b0, 1'b0, 1);
    send_word(32'hccddeeff, 1'b0, 1'b0, 1);

    // Two identical plaintext blocks back to back
    send_block(128'h0123456789abcdeffedcba9876543210, 1'b0, 1'b1, 1);
    send_block(128'h0123456789abcdeffedcba9876543210, 1'b0, 1'b1, 1);

    // Reset during RUN
    send_block(FIPS_PT, 1'b0, 1'b1, 0);
    repeat (5) @(negedge HCLK);
    do_reset("mid_run");
    watch_quiet("quiet_after_run_reset");

    // Reset during DRAIN word 2
    send_block(FIPS_KEY, 1'b1, 1'b0, 1);
    send_block(FIPS_PT, 1'b0, 1'b1, 0);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge HCLK);
      guard++;
    end
    check("drain_start", 128'(out_valid), 128'(1));
    drain(2, 1'b0);
    do_reset("mid_drain");
    watch_quiet("quiet_after_drain_reset");

    // Randomised groups, with occasional interrupted partial groups
    for (int g = 0; g < 24; g++) begin
      rk = ($urandom_range(0, 3) == 0);
      re = 1'($urandom);
      rb = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 4) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++)
          send_word($urandom, ~rk, 1'($urandom), 1);
      end
      for (int i = 0; i < 4; i++) begin
        send_word(rb[127-32*i -: 32], rk, (i == 0) ? re : 1'($urandom), 1);
        repeat ($urandom_range(0, 2)) @(negedge HCLK);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
